// File: rtl/axi3_mem_slave.sv
// axi3_mem_slave: AXI3 slave endpoint backed by a byte-strobed word memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one burst in flight per path.
module axi3_mem_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int IW    = 1,
    parameter int DEPTH = 1024
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [IW-1:0]   AWID,
    input  logic [AW-1:0]   AWADDR,
    input  logic [7:0]      AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [DW-1:0]   WDATA,
    input  logic [DW/8-1:0] WSTRB,
    input  logic            WLAST,
    input  logic            WVALID,
    output logic            WREADY,
    output logic [IW-1:0]   BID,
    output logic [1:0]      BRESP,
    output logic            BVALID,
    input  logic            BREADY,
    input  logic [IW-1:0]   ARID,
    input  logic [AW-1:0]   ARADDR,
    input  logic [7:0]      ARLEN,
    input  logic [2:0]      ARSIZE,
    input  logic [1:0]      ARBURST,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [IW-1:0]   RID,
    output logic [DW-1:0]   RDATA,
    output logic [1:0]      RRESP,
    output logic            RLAST,
    output logic            RVALID,
    input  logic            RREADY
);
    localparam int NB  = DW / 8;
    localparam int OFS = $clog2(NB);
    localparam int MW  = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] s, m;
        s = AW'(1) << size;
        m = (AW'(len) + AW'(1)) * s - AW'(1);
        return burst == 2'd0 ? a : burst == 2'd2 ? (a & ~m) | ((a + s) & m) : a + s;
    endfunction

    function automatic logic bad(input logic [AW-1:0] a, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        logic wrap;
        wrap = burst == 2'd2;
        return len[7:4] != 4'd0 || size > 3'(OFS) || burst == 2'd3 ||
               (wrap && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
               (wrap && (a & ((AW'(1) << size) - AW'(1))) != '0);
    endfunction

    function automatic logic oob(input logic [AW-1:0] a);
        return (a >> OFS) >= AW'(DEPTH);
    endfunction

    function automatic logic [MW-1:0] idx(input logic [AW-1:0] a);
        return MW'(a >> OFS);
    endfunction

    logic [DW-1:0] mem [DEPTH];
    logic          live;
    wstate_t       ws, ws_n;
    rstate_t       rs, rs_n;
    logic [IW-1:0] w_id, r_id;
    logic [AW-1:0] w_addr, r_addr;
    logic [7:0]    w_len, w_cnt, r_len, r_cnt;
    logic [2:0]    w_size, r_size;
    logic [1:0]    w_burst, r_burst;
    logic          w_bad, w_err, r_bad;

    logic aw_hs, w_hs, ar_hs, r_hs, w_end, wr_en;
    logic aw_bad, ar_bad, r_ld_err, r_ld_last, r_ld;
    logic [AW-1:0] r_nx, r_ld_addr;

    // live holds the READYs low through reset and for the release edge
    assign AWREADY = live && ws == W_IDLE;
    assign WREADY  = ws == W_DATA;
    assign BVALID  = ws == W_RESP;
    assign BID     = w_id;
    assign BRESP   = {w_err, 1'b0};
    assign ARREADY = live && rs == R_IDLE;
    assign RVALID  = rs == R_DATA;
    assign RID     = r_id;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign ar_hs  = ARVALID && ARREADY;
    assign r_hs   = RVALID && RREADY;
    assign w_end  = w_cnt == w_len;
    assign aw_bad = bad(AWADDR, AWLEN, AWSIZE, AWBURST);
    assign ar_bad = bad(ARADDR, ARLEN, ARSIZE, ARBURST);
    assign wr_en  = w_hs && !w_bad && !oob(w_addr);

    assign r_nx      = nxt(r_addr, r_len, r_size, r_burst);
    assign r_ld      = ar_hs || (r_hs && !RLAST);
    assign r_ld_addr = ar_hs ? ARADDR : r_nx;
    assign r_ld_err  = (ar_hs ? ar_bad : r_bad) || oob(r_ld_addr);
    assign r_ld_last = ar_hs ? ARLEN == 8'd0 : r_cnt + 8'd1 == r_len;

    always_comb begin
        ws_n = ws;
        rs_n = rs;
        ws_n = aw_hs ? W_DATA : (w_hs && w_end) ? W_RESP : (BVALID && BREADY) ? W_IDLE : ws;
        rs_n = ar_hs ? R_DATA : (r_hs && RLAST) ? R_IDLE : rs;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ws      <= W_IDLE;
            live    <= 1'b0;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            ws   <= ws_n;
            live <= 1'b1;
            if (aw_hs) begin
                w_id    <= AWID;
                w_addr  <= AWADDR;
                w_len   <= AWLEN;
                w_size  <= AWSIZE;
                w_burst <= AWBURST;
                w_cnt   <= '0;
                w_bad   <= aw_bad;
                w_err   <= aw_bad;
            end else if (w_hs) begin
                w_addr <= nxt(w_addr, w_len, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err || oob(w_addr) || (WLAST != w_end);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_en)
            for (int i = 0; i < NB; i++)
                if (WSTRB[i]) mem[idx(w_addr)][8*i +: 8] <= WDATA[8*i +: 8];
    end

    // Registered read sees the pre-write contents on a same-cycle collision
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rs      <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
            RDATA   <= '0;
            RRESP   <= '0;
            RLAST   <= 1'b0;
        end else begin
            rs <= rs_n;
            if (ar_hs) begin
                r_id    <= ARID;
                r_addr  <= ARADDR;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= ARBURST;
                r_cnt   <= '0;
                r_bad   <= ar_bad;
            end else if (r_hs && !RLAST) begin
                r_addr <= r_nx;
                r_cnt  <= r_cnt + 8'd1;
            end
            if (r_ld) begin
                RDATA <= r_ld_err ? '0 : mem[idx(r_ld_addr)];
                RRESP <= {r_ld_err, 1'b0};
                RLAST <= r_ld_last;
            end
        end
    end
endmodule

// File: tb/tb_axi3_mem_slave.sv
// tb_axi3_mem_slave: directed plus randomized bursts against a byte-level memory model.
module tb_axi3_mem_slave;
    localparam int DEPTH = 1024;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [0:0]  AWID = '0, ARID = '0, BID, RID;
    logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, RDATA;
    logic [7:0]  AWLEN = '0, ARLEN = '0;
    logic [2:0]  AWSIZE = '0, ARSIZE = '0;
    logic [1:0]  AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 0, WVALID = 0, WLAST = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;

    int checks = 0, failures = 0;
    int wlast_bad = -1;
    logic [7:0]  mb [int unsigned];
    logic [31:0] wd [32];
    logic [3:0]  wsb [32];
    logic [31:0] got [32];
    logic [1:0]  gresp [32];
    logic [31:0] keep0, keep1;

    axi3_mem_slave #(.AW(32), .DW(32), .IW(1), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit burst_bad(input int unsigned a, input int l, input int s, input int b);
        int unsigned sz;
        sz = 1 << s;
        return l > 15 || sz > 4 || b == 3 || (b == 2 && !(l == 1 || l == 3 || l == 7 || l == 15)) ||
               (b == 2 && a % sz != 0);
    endfunction

    function automatic int unsigned beat_addr(input int unsigned a, input int l, input int s,
                                              input int b, input int i);
        int unsigned sz, tot, base;
        sz = 1 << s;
        tot = (l + 1) * sz;
        base = a - a % tot;
        if (b == 0) return a;
        if (b == 2) return base + (a - base + i * sz) % tot;
        return a + i * sz;
    endfunction

    function automatic bit known(input int unsigned w);
        return mb.exists(w*4) && mb.exists(w*4+1) && mb.exists(w*4+2) && mb.exists(w*4+3);
    endfunction

    function automatic logic [31:0] mword(input int unsigned w);
        return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
    endfunction

    task automatic aw_send(input logic id, input int unsigned a, input int l, input int s, input int b);
        int n = 0;
        AWID = id; AWADDR = a; AWLEN = 8'(l); AWSIZE = 3'(s); AWBURST = 2'(b); AWVALID = 1;
        while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
        chk("awready", AWREADY, 1);
        tick();
        AWVALID = 0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] st, input bit last);
        int n = 0;
        WDATA = d; WSTRB = st; WLAST = last; WVALID = 1;
        while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
        chk("wready", WREADY, 1);
        tick();
        WVALID = 0;
    endtask

    task automatic b_get(input logic id, input logic [1:0] resp);
        int n = 0;
        BREADY = 1;
        while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
        chk("bvalid", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, resp);
        tick();
        BREADY = 0;
    endtask

    task automatic model_write(input int unsigned ba, input logic [31:0] d, input logic [3:0] st);
        for (int k = 0; k < 4; k++)
            if (st[k]) mb[(ba / 4) * 4 + k] = d[8*k +: 8];
    endtask

    task automatic wr(input logic id, input int unsigned a, input int l, input int s, input int b);
        bit bad, err, last;
        int unsigned ba;
        bad = burst_bad(a, l, s, b);
        err = bad;
        aw_send(id, a, l, s, b);
        for (int i = 0; i <= l; i++) begin
            ba = beat_addr(a, l, s, b, i);
            last = (i == l) ^ (i == wlast_bad);
            w_send(wd[i % 32], wsb[i % 32], last);
            if (last != (i == l)) err = 1;
            if (ba / 4 >= DEPTH) err = 1;
            else if (!bad) model_write(ba, wd[i % 32], wsb[i % 32]);
        end
        b_get(id, err ? 2'd2 : 2'd0);
    endtask

    task automatic rd(input logic id, input int unsigned a, input int l, input int s, input int b,
                      input bit stall);
        bit bad, err;
        int unsigned ba;
        int n = 0;
        bad = burst_bad(a, l, s, b);
        ARID = id; ARADDR = a; ARLEN = 8'(l); ARSIZE = 3'(s); ARBURST = 2'(b); ARVALID = 1;
        while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
        chk("arready", ARREADY, 1);
        tick();
        ARVALID = 0;
        for (int i = 0; i <= l; i++) begin
            ba = beat_addr(a, l, s, b, i);
            err = bad || ba / 4 >= DEPTH;
            chk("rvalid", RVALID, 1);
            got[i % 32] = RDATA;
            gresp[i % 32] = RRESP;
            chk("rresp", RRESP, err ? 2 : 0);
            chk("rlast", RLAST, i == l);
            chk("rid", RID, id);
            if (err) chk("rdata_err", RDATA, 0);
            else if (known(ba / 4)) chk("rdata", RDATA, mword(ba / 4));
            if (stall) begin
                RREADY = 0;
                tick();
                chk("rvalid_hold", RVALID, 1);
                chk("rdata_hold", RDATA, got[i % 32]);
            end
            RREADY = 1;
            tick();
        end
        RREADY = 0;
        chk("arready_after", ARREADY, 1);
    endtask

    initial begin
        int unsigned a;
        int l, s, b;
        for (int i = 0; i < 32; i++) wsb[i] = 4'hF;
        repeat (2) tick();
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_outs", {BID, BRESP, RID, RDATA, RRESP, RLAST}, 0);
        ARESET = 0;
        tick();
        chk("rel_awready", AWREADY, 1);
        chk("rel_arready", ARREADY, 1);

        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        wr(1, 'h100, 3, 2, 1);
        rd(1, 'h100, 3, 2, 1, 0);
        chk("t1_data", {got[0], got[1], got[2], got[3]}, {32'h11, 32'h22, 32'h33, 32'h44});

        wd[0] = 0;
        wr(0, 'h0, 0, 2, 1);
        wd[0] = 32'hAABBCCDD; wsb[0] = 4'h5;
        wr(0, 'h0, 0, 2, 1);
        wsb[0] = 4'hF;
        rd(0, 'h0, 0, 2, 1, 0);
        chk("t2_strobe", got[0], 32'h00BB00DD);

        wd[0] = 32'hA1; wd[1] = 32'hA2; wd[2] = 32'hA3; wd[3] = 32'hA4;
        wr(1, 'h108, 3, 2, 2);
        rd(0, 'h100, 3, 2, 1, 0);
        chk("t3_wrap_order", {got[0], got[1], got[2], got[3]}, {32'hA3, 32'hA4, 32'hA1, 32'hA2});
        rd(1, 'h108, 3, 2, 2, 0);
        wd[0] = 32'hE0; wd[1] = 32'hE1; wd[2] = 32'hE2;
        wr(0, 'h100, 2, 2, 2);
        rd(0, 'h100, 3, 2, 1, 0);
        chk("t3_wrap_bad_nochange", got[0], 32'hA3);

        for (int i = 0; i < 17; i++) wd[i] = 32'hBAD0 + i;
        wr(1, 'h100, 16, 2, 1);
        rd(0, 'h100, 3, 2, 1, 0);
        chk("t4_len16_nochange", got[1], 32'hA4);
        rd(1, 'h100, 1, 3, 1, 0);
        chk("t4_size3", {gresp[0], gresp[1], got[0], got[1]}, {2'd2, 2'd2, 64'd0});

        rd(0, 'h100, 3, 2, 1, 1);
        wd[0] = 32'hF00DCAFE;
        wr(0, 'hFFC, 0, 2, 1);
        rd(0, 'hFFC, 1, 2, 1, 0);
        chk("t5_oob", {gresp[0], gresp[1], got[0]}, {2'd0, 2'd2, 32'hF00DCAFE});

        wlast_bad = 0;
        wd[0] = 32'h5A5A0001; wd[1] = 32'h5A5A0002;
        wr(1, 'h200, 1, 2, 1);
        wlast_bad = -1;
        rd(1, 'h200, 1, 2, 1, 0);

        AWID = 1; AWADDR = 'h300; AWLEN = 0; AWSIZE = 2; AWBURST = 1; AWVALID = 1;
        WDATA = 32'h12345678; WSTRB = 4'hF; WLAST = 1; WVALID = 1;
        chk("tp_awready", AWREADY, 1);
        tick();
        AWVALID = 0;
        chk("tp_wready", WREADY, 1);
        tick();
        WVALID = 0;
        chk("tp_bvalid", BVALID, 1);
        model_write('h300, 32'h12345678, 4'hF);
        b_get(1, 0);
        rd(0, 'h300, 0, 2, 1, 0);

        for (int t = 0; t < 25; t++) begin
            a = $urandom_range(0, 'h10FF);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 17) : $urandom_range(0, 15);
            s = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            if (b == 2 && $urandom_range(0, 3) != 0) begin
                l = (2 << $urandom_range(0, 3)) - 1;
                s = $urandom_range(0, 2);
                a = a & ~((1 << s) - 1);
            end
            for (int i = 0; i < 32; i++) begin
                wd[i] = $urandom;
                wsb[i] = 4'($urandom_range(0, 15));
            end
            wr(1'($urandom_range(0, 1)), a, l, s, b);
            rd(1'($urandom_range(0, 1)), a, l, s, b, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 32; i++) wsb[i] = 4'hF;
        keep0 = 32'hC0DE0000; keep1 = 32'hC0DE0001;
        aw_send(1, 'h400, 3, 2, 1);
        w_send(keep0, 4'hF, 0);
        w_send(keep1, 4'hF, 0);
        model_write('h400, keep0, 4'hF);
        model_write('h404, keep1, 4'hF);
        ARESET = 1;
        #1;
        chk("t6_rst_bvalid", BVALID, 0);
        chk("t6_rst_awready", AWREADY, 0);
        chk("t6_rst_wready", WREADY, 0);
        tick();
        tick();
        chk("t6_rst_bvalid2", BVALID, 0);
        ARESET = 0;
        tick();
        chk("t6_rel_awready", AWREADY, 1);
        wd[0] = 32'h600D0001; wd[1] = 32'h600D0002;
        wr(0, 'h480, 1, 2, 1);
        rd(0, 'h480, 1, 2, 1, 0);
        rd(0, 'h400, 1, 2, 1, 0);
        chk("t6_persist", {got[0], got[1]}, {keep0, keep1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
